// File: rtl/prog_loader.sv
// Boot loader: receives a framed program image over a valid/ready byte stream, assembles
// 16-bit words (high byte first), writes them into program memory from address 0 upward,
// checks an XOR checksum and keeps the CPU in reset until an image loads cleanly.
module prog_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [15:0]       pm_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    StWaitCount,
    StWaitHi,
    StWaitLo,
    StWaitSum,
    StDone,
    StError
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          count_q, count_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          acc_q, acc_d;
  logic [31:0]         tmo_q, tmo_d;
  logic                pm_we_q, pm_we_d;
  logic [ADDR_W-1:0]   pm_addr_q, pm_addr_d;
  logic [15:0]         pm_wdata_q, pm_wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   words_q, words_d;

  logic                waiting;
  logic                accept;
  logic                tmo_hit;
  logic [ADDR_W-1:0]   words_inc;

  // Handshake, timeout detection and all next-state values.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    acc_d      = acc_q;
    tmo_d      = tmo_q;
    pm_we_d    = 1'b0;
    pm_addr_d  = pm_addr_q;
    pm_wdata_d = pm_wdata_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;
    words_d    = words_q;

    waiting   = state_q inside {StWaitHi, StWaitLo, StWaitSum};
    in_ready  = (state_q inside {StWaitCount, StWaitHi, StWaitLo, StWaitSum}) && !rst && !start;
    accept    = in_valid && in_ready;
    words_inc = words_q + ADDR_W'(1);
    // Fires on the edge where the idle count would reach TIMEOUT.
    tmo_hit   = (TIMEOUT != 0) && waiting && !accept && ((tmo_q + 32'd1) == TIMEOUT);

    if (start) begin
      state_d   = StWaitCount;
      acc_d     = 8'h00;
      cpu_rst_d = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b0;
      words_d   = '0;
    end else if (tmo_hit) begin
      state_d   = StError;
      cpu_rst_d = 1'b1;
      err_d     = 1'b1;
    end else if (accept) begin
      unique case (state_q)
        StWaitCount: begin
          count_d = in_data;
          acc_d   = acc_q ^ in_data;
          words_d = '0;
          state_d = (in_data != 8'h00) ? StWaitHi : StWaitSum;
        end
        StWaitHi: begin
          hi_d    = in_data;
          acc_d   = acc_q ^ in_data;
          state_d = StWaitLo;
        end
        StWaitLo: begin
          acc_d      = acc_q ^ in_data;
          pm_we_d    = 1'b1;
          pm_addr_d  = words_q;
          pm_wdata_d = {hi_q, in_data};
          words_d    = words_inc;
          state_d    = (words_inc == ADDR_W'(count_q)) ? StWaitSum : StWaitHi;
        end
        StWaitSum: begin
          if (in_data == acc_q) begin
            state_d   = StDone;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = StError;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Idle counter restarts on every accepted byte and whenever the state changes.
    if (start || accept || (state_d != state_q)) begin
      tmo_d = 32'd0;
    end else if (waiting) begin
      tmo_d = tmo_q + 32'd1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StWaitCount;
      count_q    <= 8'h00;
      hi_q       <= 8'h00;
      acc_q      <= 8'h00;
      tmo_q      <= 32'd0;
      pm_we_q    <= 1'b0;
      pm_addr_q  <= '0;
      pm_wdata_q <= 16'h0000;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      acc_q      <= acc_d;
      tmo_q      <= tmo_d;
      pm_we_q    <= pm_we_d;
      pm_addr_q  <= pm_addr_d;
      pm_wdata_q <= pm_wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      words_q    <= words_d;
    end
  end

  assign pm_we        = pm_we_q;
  assign pm_addr      = pm_addr_q;
  assign pm_wdata     = pm_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a per-cycle vector table covering nominal load, bad
// checksum, empty image, abort/reload, gapped valid and mid-frame reset, followed by a
// hand-written idle-timeout sequence.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, pm_we, cpu_rst, load_done, load_error;
  logic [7:0]  pm_addr, words_loaded;
  logic [15:0] pm_wdata;

  int checks = 0;
  int fails  = 0;

  prog_loader #(
    .ADDR_W (8),
    .TIMEOUT(20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .pm_we       (pm_we),
    .pm_addr     (pm_addr),
    .pm_wdata    (pm_wdata),
    .cpu_rst     (cpu_rst),
    .load_done   (load_done),
    .load_error  (load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Inputs for one cycle, and the outputs expected during that cycle (before its edge).
  typedef struct {
    logic        rst;
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic [36:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic v, input logic [7:0] d,
                     input logic rdy, input logic we, input logic [7:0] a,
                     input logic [15:0] wd, input logic cr, input logic dn, input logic er,
                     input logic [7:0] w);
    vec_t x;
    x.rst   = r;
    x.start = s;
    x.valid = v;
    x.data  = d;
    x.exp   = {rdy, we, a, wd, cr, dn, er, w};
    vecs.push_back(x);
  endtask

  function automatic logic [36:0] outs();
    return {in_ready, pm_we, pm_addr, pm_wdata, cpu_rst, load_done, load_error, words_loaded};
  endfunction

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    int we_seen;

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);

    //   rst s v data   rdy we addr  wdata    crst dn er words
    add(1, 0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'd0);  // reset state
    // Nominal load, back-to-back
    add(0, 0, 1, 8'h02, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h62, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h0A, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h64, 1, 1, 8'h00, 16'h620A, 1, 0, 0, 8'd1);
    add(0, 0, 1, 8'h05, 1, 0, 8'h00, 16'h620A, 1, 0, 0, 8'd1);
    add(0, 0, 1, 8'h0B, 1, 1, 8'h01, 16'h6405, 1, 0, 0, 8'd2);
    add(0, 0, 0, 8'h00, 0, 0, 8'h01, 16'h6405, 0, 1, 0, 8'd2);
    add(0, 0, 1, 8'h55, 0, 0, 8'h01, 16'h6405, 0, 1, 0, 8'd2);  // ignored in DONE
    add(0, 1, 1, 8'h02, 0, 0, 8'h01, 16'h6405, 0, 1, 0, 8'd2);  // start blocks byte
    // Bad checksum
    add(0, 0, 1, 8'h02, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h62, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h0A, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h64, 1, 1, 8'h00, 16'h620A, 1, 0, 0, 8'd1);
    add(0, 0, 1, 8'h05, 1, 0, 8'h00, 16'h620A, 1, 0, 0, 8'd1);
    add(0, 0, 1, 8'h0C, 1, 1, 8'h01, 16'h6405, 1, 0, 0, 8'd2);
    add(0, 0, 0, 8'h00, 0, 0, 8'h01, 16'h6405, 1, 0, 1, 8'd2);
    add(0, 1, 0, 8'h00, 0, 0, 8'h01, 16'h6405, 1, 0, 1, 8'd2);
    // Empty image
    add(0, 0, 1, 8'h00, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h00, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h01, 16'h6405, 0, 1, 0, 8'd0);
    add(0, 1, 0, 8'h00, 0, 0, 8'h01, 16'h6405, 0, 1, 0, 8'd0);
    // Abort mid-frame, then reload
    add(0, 0, 1, 8'h01, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h62, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(0, 1, 1, 8'h12, 0, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h01, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h12, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h34, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h27, 1, 1, 8'h00, 16'h1234, 1, 0, 0, 8'd1);
    add(0, 0, 0, 8'h00, 0, 0, 8'h00, 16'h1234, 0, 1, 0, 8'd1);
    add(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h1234, 0, 1, 0, 8'd1);
    // Gapped valid
    add(0, 0, 0, 8'h00, 1, 0, 8'h00, 16'h1234, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h02, 1, 0, 8'h00, 16'h1234, 1, 0, 0, 8'd0);
    add(0, 0, 0, 8'h00, 1, 0, 8'h00, 16'h1234, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h62, 1, 0, 8'h00, 16'h1234, 1, 0, 0, 8'd0);
    add(0, 0, 0, 8'h00, 1, 0, 8'h00, 16'h1234, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h0A, 1, 0, 8'h00, 16'h1234, 1, 0, 0, 8'd0);
    add(0, 0, 0, 8'h00, 1, 1, 8'h00, 16'h620A, 1, 0, 0, 8'd1);
    add(0, 0, 1, 8'h64, 1, 0, 8'h00, 16'h620A, 1, 0, 0, 8'd1);
    add(0, 0, 0, 8'h00, 1, 0, 8'h00, 16'h620A, 1, 0, 0, 8'd1);
    add(0, 0, 1, 8'h05, 1, 0, 8'h00, 16'h620A, 1, 0, 0, 8'd1);
    add(0, 0, 0, 8'h00, 1, 1, 8'h01, 16'h6405, 1, 0, 0, 8'd2);
    add(0, 0, 1, 8'h0B, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd2);
    add(0, 0, 0, 8'h00, 0, 0, 8'h01, 16'h6405, 0, 1, 0, 8'd2);
    add(0, 1, 0, 8'h00, 0, 0, 8'h01, 16'h6405, 0, 1, 0, 8'd2);
    // Reset mid-frame, right after a write
    add(0, 0, 1, 8'h02, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h62, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h0A, 1, 0, 8'h01, 16'h6405, 1, 0, 0, 8'd0);
    add(1, 0, 1, 8'h64, 0, 1, 8'h00, 16'h620A, 1, 0, 0, 8'd1);
    add(0, 0, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 8'd0);
    // Timeout lead-in: count 01, hi 62, then idle
    add(0, 0, 1, 8'h01, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 8'd0);
    add(0, 0, 1, 8'h62, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst      = vecs[i].rst;
      start    = vecs[i].start;
      in_valid = vecs[i].valid;
      in_data  = vecs[i].data;
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // The edge after the last vector accepts 0x62; count edges until ERROR appears.
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    check("tmo_not_early", {36'd0, load_error}, 37'd0);
    n       = 0;
    we_seen = 0;
    while (!load_error && n < 40) begin
      @(negedge clk);
      #1;
      n++;
      if (pm_we) we_seen++;
    end
    check("tmo_cycles", 37'(n), 37'd20);
    check("tmo_no_write", 37'(we_seen), 37'd0);
    check("tmo_outputs", outs(), {1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream boot loader that sits directly upstream of the CPU's program memory.
- Receives a framed program image over a valid/ready byte interface and assembles 16-bit instruction words, high byte first.
- Writes the words into program memory from address 0 upward, verifies an XOR checksum, and holds the CPU in reset until a load completes successfully.
- Replaces hierarchical memory preloading, so programs can be loaded in the normal flow.

Parameters:
- ADDR_W, 8: program memory address width; must be >= 8 so a 255-word image fits.
- TIMEOUT, 1000: maximum idle cycles allowed between accepted bytes inside a frame; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; aborts or re-arms the loader.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- pm_we  output  1  program memory write strobe, one cycle per word.
- pm_addr  output  ADDR_W  program memory write address.
- pm_wdata  output  16  instruction word to write.
- cpu_rst  output  1  reset to the CPU; high until a load succeeds.
- load_done  output  1  valid image loaded.
- load_error  output  1  checksum mismatch or timeout.
- words_loaded  output  ADDR_W  count of words written in the current frame.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=WAIT_COUNT, pm_we=0, pm_addr=0, pm_wdata=0, cpu_rst=1, load_done=0, load_error=0, words_loaded=0, checksum accumulator=0, timeout counter=0.
- Handshake: a byte is accepted on a rising edge where in_valid && in_ready.
  - in_ready = (state is WAIT_COUNT, WAIT_HI, WAIT_LO or WAIT_SUM) && !rst.
  - in_ready is 1 in the first cycle after rst deasserts.
- Frame format: count byte N (0..255), then 2N payload bytes (hi, lo per word), then a checksum byte.
  - The checksum byte must equal the XOR of the count byte and all payload bytes.
- Accumulator: XOR-accumulates every accepted byte except the checksum byte.
- State transitions on accept:
  - WAIT_COUNT: latch N; clear words_loaded. Go to WAIT_HI if N>0, else go to WAIT_SUM.
  - WAIT_HI: latch the byte as the high byte; go to WAIT_LO.
  - WAIT_LO: on the next edge, pm_we=1 for exactly one cycle, pm_wdata={hi,lo}, pm_addr=words_loaded (pre-increment value); words_loaded increments on that same edge. Go to WAIT_SUM if this was word N, else go to WAIT_HI.
  - WAIT_SUM: byte == accumulator -> DONE; else -> ERROR.
- DONE: in_ready=0, load_done=1, cpu_rst=0 (registered; deasserts on the edge that enters DONE).
- ERROR: in_ready=0, load_error=1, cpu_rst=1.
- Timeout:
  - The counter clears on every accepted byte and on state entry.
  - It increments each cycle in WAIT_HI, WAIT_LO or WAIT_SUM without an accept.
  - When it reaches TIMEOUT: go to ERROR.
  - WAIT_COUNT never times out.
- start: in any state, a start pulse returns the FSM to WAIT_COUNT next cycle.
  - Clears load_done, load_error, words_loaded, the accumulator and the timeout counter.
  - Sets cpu_rst=1.
  - A byte offered in the same cycle as start is not accepted (in_ready is forced 0 during start).
  - Memory contents already written are left as-is.
- Priority: rst > start > timeout > byte accept.
- pm_addr wraps modulo 2^ADDR_W; it cannot wrap when ADDR_W >= 8.
- Back-to-back bytes (in_valid held high) are accepted every cycle; the pm_we pulse overlaps acceptance of the next hi byte.

Test Plan:
- Nominal load: bytes 02,62,0A,64,05,0B fed back-to-back after reset -> pm_we pulses at addr 0 data 620A and at addr 1 data 6405; words_loaded=2; load_done=1; cpu_rst=0; in_ready=0.
- Bad checksum: same stream with final byte 0C -> both words written; load_error=1; cpu_rst stays 1; load_done=0.
- Empty image: bytes 00,00 -> no pm_we; load_done=1; cpu_rst=0; words_loaded=0.
- Timeout: TIMEOUT=20; send 01,62 then idle -> ERROR exactly 20 cycles after the 62 accept; no pm_we.
- Abort and reload: start pulse mid-frame after 01,62, then full frame 01,12,34,27 -> single write addr 0 data 1234; load_done=1.
- Gapped valid plus reset mid-load: in_valid toggling every other cycle gives the same writes as the nominal case; asserting rst mid-frame returns all outputs to reset values next cycle.
